mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  decoded MULT issue; sampled on the clk edge.
- instFunc  input  6  function field of the current instruction.
- opA  input  32  multiplicand (rs).
- opB  input  32  multiplier (rt).
- busy  output  1  multiply in progress.
- done  output  1  one-cycle completion pulse.
- stall  output  1  pipeline hold request.
- hiOut  output  32  architectural HI register.
- loOut  output  32  architectural LO register.
- mfResult  output  32  HI or LO selected by MFHI/MFLO.
REQ-002 The reset port SHALL be synchronous and active-high, and the block SHALL use one clock only (clk, rst).

Function
REQ-003 The FSM SHALL have two states: IDLE and RUN.
- IDLE -> RUN when start=1.
- RUN -> IDLE after the 32nd iteration.
REQ-004 On an accepted start, opA/opB SHALL be captured, and a 6-bit iteration counter SHALL be cleared.
REQ-005 Each RUN cycle SHALL perform one radix-2 shift-add step on a 64-bit accumulator.
REQ-006 busy SHALL be 1 for exactly the 32 RUN cycles following the accepting edge.
REQ-007 HI/LO SHALL update only on the edge ending the 32nd RUN cycle.
- done SHALL be 1 for exactly the one following cycle.
REQ-008 HI/LO SHALL hold their previous values throughout RUN.
REQ-009 start while busy=1 SHALL be ignored (no restart, no capture).
REQ-010 start in the done cycle (busy=0) SHALL be accepted normally.
REQ-011 stall SHALL equal busy AND (start OR instFunc=MFHI 6'b010000 OR instFunc=MFLO 6'b010010).
REQ-012 mfResult SHALL be combinational:
- hiOut when instFunc=MFHI;
- loOut when instFunc=MFLO;
- 32'h0 otherwise.
REQ-013 The product SHALL be full 64-bit, with no truncation or overflow flag.
- HI = product[63:32].
- LO = product[31:0].

Reset
REQ-014 When rst=1 at an edge, the block SHALL set: state=IDLE, counter=0, busy=0, done=0, hiOut=0, loOut=0, accumulator=0.
REQ-015 rst SHALL take priority over start in the same cycle.
REQ-016 rst during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-017 With macro MULT_SIGNED_EN defined, operands SHALL be two's-complement signed.
- Magnitudes are multiplied.
- The 64-bit result is negated at completion when the sign bits differ.
- Latency is unchanged.
REQ-018 Without MULT_SIGNED_EN, operands SHALL be unsigned, and the sign-correction logic SHALL not be present.

Structure
REQ-019 The shared package mips_pkg SHALL hold:
- FUNC_MULT/FUNC_MFHI/FUNC_MFLO constants;
- the mult FSM state typedef;
- the MULT_ITER=32 constant.
REQ-020 The shift-add accumulator and counter SHALL live in one sub-module, mult_shift_add_dp.
- mult_ctrl contains the FSM, HI/LO registers, stall logic and mfResult mux.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic: opA=7, opB=6, start one cycle -> busy high 32 cycles; then HI=0, LO=42, done for 1 cycle.
- Unsigned, no MULT_SIGNED_EN: 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed, with MULT_SIGNED_EN: -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; -1*-1 -> HI=0, LO=1.
- Read during busy: instFunc=MFLO while busy -> stall=1, mfResult=old LO.
  - After done -> stall=0, mfResult=new LO.
- Back-to-back: start during busy -> ignored, stall=1; start in the done cycle -> new 32-cycle run.
- Reset mid-run: rst at RUN cycle 10 -> busy=0, HI=LO=0, no done.
  - A subsequent start completes correctly.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants and types for the iterative multiplier.
// Signed operation is enabled by defining MULT_SIGNED_EN.
package mips_pkg;

    localparam int MULT_ITER = 32;

    localparam logic [5:0] FUNC_MULT = 6'b011000;
    localparam logic [5:0] FUNC_MFHI = 6'b010000;
    localparam logic [5:0] FUNC_MFLO = 6'b010010;

    typedef enum logic {
        MULT_IDLE,
        MULT_RUN
    } mult_state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Radix-2 shift-add datapath: 64-bit accumulator plus iteration counter.
// Magnitude/sign-correction logic exists only with MULT_SIGNED_EN.
module mult_shift_add_dp
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        last,
    output logic [63:0] product
);

    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] mcand;
    logic [32:0] sum;
    logic [5:0]  count;
    logic [31:0] load_a;
    logic [31:0] load_b;

`ifdef MULT_SIGNED_EN
    logic neg;

    assign load_a = mag32(a);
    assign load_b = mag32(b);
`else
    assign load_a = a;
    assign load_b = b;
`endif

    // Upper half adds the multiplicand when the current multiplier bit is set,
    // then the whole accumulator shifts right; the multiplier drains out of LO.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
        acc_next = {sum, acc[31:1]};
    end

`ifdef MULT_SIGNED_EN
    assign product = neg ? (~acc_next + 64'd1) : acc_next;
`else
    assign product = acc_next;
`endif

    assign last = (count == 6'(MULT_ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= 64'd0;
            mcand <= 32'd0;
            count <= 6'd0;
`ifdef MULT_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else if (load) begin
            acc   <= {32'd0, load_b};
            mcand <= load_a;
            count <= 6'd0;
`ifdef MULT_SIGNED_EN
            neg   <= a[31] ^ b[31];
`endif
        end else if (step) begin
            acc   <= acc_next;
            count <= count + 6'd1;
        end
    end

endmodule

// File: rtl/mult_ctrl.sv
// Multi-cycle MULT controller: FSM, HI/LO registers, stall and MFHI/MFLO mux.
// Define MULT_SIGNED_EN for two's-complement operands.
module mult_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  instFunc,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hiOut,
    output logic [31:0] loOut,
    output logic [31:0] mfResult
);

    mult_state_t state;
    logic        load;
    logic        step;
    logic        last;
    logic [63:0] product;
    logic        is_mfhi;
    logic        is_mflo;

    assign load = (state == MULT_IDLE) && start;
    assign step = (state == MULT_RUN);

    mult_shift_add_dp u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .a       (opA),
        .b       (opB),
        .last    (last),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MULT_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hiOut <= 32'd0;
            loOut <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                MULT_IDLE: begin
                    if (start) begin
                        state <= MULT_RUN;
                        busy  <= 1'b1;
                    end
                end
                MULT_RUN: begin
                    // A start seen here is deliberately dropped.
                    if (last) begin
                        state <= MULT_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hiOut <= product[63:32];
                        loOut <= product[31:0];
                    end
                end
                default: begin
                    state <= MULT_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign is_mfhi = (instFunc == FUNC_MFHI);
    assign is_mflo = (instFunc == FUNC_MFLO);

    assign stall = busy && (start || is_mfhi || is_mflo);

    always_comb begin
        mfResult = 32'd0;
        if (is_mfhi) begin
            mfResult = hiOut;
        end else if (is_mflo) begin
            mfResult = loOut;
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl against an arithmetic reference model.
module tb_mult_ctrl;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  instFunc;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hiOut;
    logic [31:0] loOut;
    logic [31:0] mfResult;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .instFunc (instFunc),
        .opA      (opA),
        .opB      (opB),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .hiOut    (hiOut),
        .loOut    (loOut),
        .mfResult (mfResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    function automatic logic [31:0] ref_mf(input logic [5:0] f, input logic [31:0] h, input logic [31:0] l);
        if (f == FUNC_MFHI) return h;
        if (f == FUNC_MFLO) return l;
        return 32'd0;
    endfunction

    // Launch a multiply and follow it cycle by cycle to the done cycle.
    // inj >= 0 fires a spurious start with fresh operands in that run cycle.
    task automatic do_run(input logic [31:0] a, input logic [31:0] b, input int inj, input string nm);
        logic [63:0] exp;
        logic        exp_stall;
        logic [31:0] exp_mf;
        exp = ref_prod(a, b);
        opA = a;
        opB = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < MULT_ITER; i++) begin
            @(negedge clk);
            exp_stall = start || instFunc == FUNC_MFHI || instFunc == FUNC_MFLO;
            exp_mf = ref_mf(instFunc, m_hi, m_lo);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || hiOut !== m_hi || loOut !== m_lo
                || stall !== exp_stall || mfResult !== exp_mf) begin
                errors++;
                $display("FAIL %s run cycle %0d: busy=%b done=%b hi=%h lo=%h stall=%b mf=%h, expected busy=1 done=0 hi=%h lo=%h stall=%b mf=%h",
                         nm, i, busy, done, hiOut, loOut, stall, mfResult, m_hi, m_lo, exp_stall, exp_mf);
            end
            if (i == inj) begin
                start = 1'b1;
                opA = $urandom;
                opB = $urandom;
                #1;
                checks++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL %s start-while-busy stall: got %b expected 1", nm, stall);
                end
            end else if (i == inj + 1) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        exp_mf = ref_mf(instFunc, m_hi, m_lo);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || hiOut !== m_hi || loOut !== m_lo
            || stall !== 1'b0 || mfResult !== exp_mf) begin
            errors++;
            $display("FAIL %s done cycle: busy=%b done=%b hi=%h lo=%h stall=%b mf=%h, expected busy=0 done=1 hi=%h lo=%h stall=0 mf=%h",
                     nm, busy, done, hiOut, loOut, stall, mfResult, m_hi, m_lo, exp_mf);
        end
    endtask

    task automatic test_idle_after(input string nm);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hiOut !== m_hi || loOut !== m_lo) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b hi=%h lo=%h, expected busy=0 done=0 hi=%h lo=%h",
                     nm, busy, done, hiOut, loOut, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        opA = 32'h1234_5678;
        opB = 32'h9abc_def0;
        instFunc = FUNC_MFHI;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hiOut !== 32'd0 || loOut !== 32'd0
            || stall !== 1'b0 || mfResult !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h stall=%b mf=%h, expected all zero",
                     busy, done, hiOut, loOut, stall, mfResult);
        end
        rst = 1'b0;
        start = 1'b0;
        test_idle_after("reset");
    endtask

    task automatic test_basic();
        instFunc = FUNC_MULT;
        do_run(32'd7, 32'd6, -1, "basic");
        checks++;
        if (hiOut !== 32'd0 || loOut !== 32'd42) begin
            errors++;
            $display("FAIL basic 7*6: hi=%h lo=%h expected hi=0 lo=2a", hiOut, loOut);
        end
        test_idle_after("basic");
    endtask

    task automatic test_extremes();
        instFunc = FUNC_MULT;
`ifdef MULT_SIGNED_EN
        do_run(-32'sd3, 32'd5, -1, "signed_m3x5");
        checks++;
        if (hiOut !== 32'hFFFF_FFFF || loOut !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL signed -3*5: hi=%h lo=%h expected hi=ffffffff lo=fffffff1", hiOut, loOut);
        end
        do_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "signed_m1xm1");
        checks++;
        if (hiOut !== 32'd0 || loOut !== 32'd1) begin
            errors++;
            $display("FAIL signed -1*-1: hi=%h lo=%h expected hi=0 lo=1", hiOut, loOut);
        end
        do_run(32'h8000_0000, 32'h8000_0000, -1, "signed_minxmin");
`else
        do_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "unsigned_max");
        checks++;
        if (hiOut !== 32'hFFFF_FFFE || loOut !== 32'h0000_0001) begin
            errors++;
            $display("FAIL unsigned max*max: hi=%h lo=%h expected hi=fffffffe lo=00000001", hiOut, loOut);
        end
        do_run(32'h8000_0000, 32'd2, -1, "unsigned_carry");
`endif
        do_run(32'd0, 32'hDEAD_BEEF, -1, "zero");
        test_idle_after("extremes");
    endtask

    task automatic test_read_busy();
        instFunc = FUNC_MFLO;
        do_run($urandom, $urandom, -1, "mflo_busy");
        instFunc = FUNC_MFHI;
        do_run($urandom, $urandom, -1, "mfhi_busy");
        test_idle_after("read_busy");
    endtask

    task automatic test_back_to_back();
        instFunc = FUNC_MULT;
        do_run($urandom, $urandom, 5, "b2b_first");
        do_run($urandom, $urandom, -1, "b2b_second");
        test_idle_after("b2b");
    endtask

    task automatic test_reset_mid_run();
        instFunc = FUNC_MFLO;
        opA = $urandom | 32'h1;
        opB = $urandom | 32'h1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hiOut !== 32'd0 || loOut !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, expected all zero",
                     busy, done, hiOut, loOut);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid quiet cycle %0d: done=%b busy=%b expected 0 0", i, done, busy);
            end
        end
        do_run($urandom, $urandom, -1, "after_reset");
        test_idle_after("reset_mid");
    endtask

    task automatic test_random();
        logic [5:0] funcs [4];
        funcs[0] = FUNC_MULT;
        funcs[1] = FUNC_MFHI;
        funcs[2] = FUNC_MFLO;
        funcs[3] = 6'b000000;
        for (int n = 0; n < 12; n++) begin
            instFunc = funcs[$urandom_range(0, 3)];
            do_run($urandom, $urandom,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 29)) : -1,
                   "random");
        end
        test_idle_after("random");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        instFunc = 6'd0;
        opA = 32'd0;
        opB = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        test_reset();
        test_basic();
        test_extremes();
        test_read_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
